// File: rtl/hdc_pkg.sv
// rtl/hdc_pkg.sv - shared encodings and tokenizer for the HDC classify sequencer
package hdc_pkg;

    typedef enum logic [2:0] {
        DP_NOP    = 3'd0,
        DP_CLEAR  = 3'd1,
        DP_ACC    = 3'd2,
        DP_SUM    = 3'd3,
        DP_THRESH = 3'd4,
        DP_SIM    = 3'd5
    } dp_op_t;

    localparam logic [1:0] RES_SPAM = 2'b00;
    localparam logic [1:0] RES_HAM  = 2'b01;
    localparam logic [1:0] RES_NONE = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_LATCH,
        ST_ACC,
        ST_SUM,
        ST_THRESH,
        ST_SIM,
        ST_COMPARE,
        ST_DONE
    } state_t;

    // Item-memory row for an ASCII byte: digits 1..10, letters 11..36 (case folded), else 0.
    function automatic logic [5:0] tokenize(input logic [7:0] c);
        logic [5:0] t;
        t = 6'd0;
        if (c >= 8'h41 && c <= 8'h5A)
            t = 6'(c - 8'd54);
        else if (c >= 8'h61 && c <= 8'h7A)
            t = 6'(c - 8'd86);
        else if (c >= 8'h30 && c <= 8'h39)
            t = 6'(c - 8'd47);
        return t;
    endfunction

endpackage

// File: rtl/hdc_sweep_cnt.sv
// rtl/hdc_sweep_cnt.sv - chunk counter shared by every hypervector pass
module hdc_sweep_cnt #(
    parameter int CHUNKS = 625,
    parameter int CW     = 10
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_run,
    output logic [CW-1:0] o_chunk,
    output logic          o_last,
    output logic          o_done
);

    logic [CW-1:0] r_chunk;
    logic          w_at_end;

    assign w_at_end = (r_chunk == CW'(CHUNKS - 1));

    // Advance one chunk per issued op; wrapping to 0 leaves the counter ready for the next pass.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_chunk <= '0;
        else if (i_run)
            r_chunk <= w_at_end ? '0 : r_chunk + CW'(1);
    end

    assign o_chunk = r_chunk;
    assign o_last  = i_run && w_at_end;
    assign o_done  = i_run && w_at_end;

endmodule

// File: rtl/hdc_classify_ctrl.sv
// rtl/hdc_classify_ctrl.sv - sequencer for the HDC spam/ham classification datapath
module hdc_classify_ctrl
    import hdc_pkg::*;
#(
    parameter int MAX_LENGTH = 200,
    parameter int NUM_CHAR   = 37,
    parameter int DIM        = 10000,
    parameter int LANES      = 16,
    localparam int CHUNKS    = DIM / LANES,
    localparam int CW        = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int SYM_W     = $clog2(NUM_CHAR)
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start_valid,
    output logic                o_start_ready,
    input  logic [7:0]          i_msg_len,
    output logic                o_char_rd_en,
    output logic [7:0]          o_char_addr,
    input  logic [7:0]          i_char_data,
    output logic [2:0]          o_dp_op,
    output logic [CW-1:0]       o_dp_chunk,
    output logic [SYM_W-1:0]    o_dp_symbol,
    output logic                o_dp_last,
    input  logic signed [31:0]  i_score_ham,
    input  logic signed [31:0]  i_score_spam,
    output logic                o_res_valid,
    input  logic                i_res_ready,
    output logic signed [1:0]   o_result,
    output logic                o_busy
);

    localparam logic [7:0] MAX_L8 = 8'(MAX_LENGTH);

    state_t                r_state;
    dp_op_t                r_dp_op;
    logic                  r_char_rd_en;
    logic [7:0]            r_char_addr;
    logic [7:0]            r_len;
    logic [SYM_W-1:0]      r_dp_symbol;
    logic                  r_res_valid;
    logic signed [1:0]     r_result;
    logic [7:0]            w_len;
    logic                  w_run;
    logic                  w_done;
    logic                  w_last;
    logic [CW-1:0]         w_chunk;

    assign w_len = (i_msg_len > MAX_L8) ? MAX_L8 : i_msg_len;
    assign w_run = (r_dp_op != DP_NOP);

    hdc_sweep_cnt #(
        .CHUNKS (CHUNKS),
        .CW     (CW)
    ) u_sweep (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_run   (w_run),
        .o_chunk (w_chunk),
        .o_last  (w_last),
        .o_done  (w_done)
    );

    // Main sequencer: walks CLEAR, per-character FETCH/LATCH/ACC, then SUM/THRESH/SIM and the final compare.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_dp_op      <= DP_NOP;
            r_char_rd_en <= 1'b0;
            r_char_addr  <= 8'd0;
            r_len        <= 8'd0;
            r_dp_symbol  <= '0;
            r_res_valid  <= 1'b0;
            r_result     <= RES_SPAM;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start_valid) begin
                        r_len       <= w_len;
                        r_char_addr <= 8'd0;
                        if (w_len == 8'd0) begin
                            r_state     <= ST_DONE;
                            r_res_valid <= 1'b1;
                            r_result    <= RES_NONE;
                        end else begin
                            r_state <= ST_CLEAR;
                            r_dp_op <= DP_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (w_done) begin
                        r_state      <= ST_FETCH;
                        r_dp_op      <= DP_NOP;
                        r_char_rd_en <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_char_rd_en <= 1'b0;
                    r_state      <= ST_LATCH;
                end
                ST_LATCH: begin
                    r_dp_symbol <= SYM_W'(tokenize(i_char_data));
                    r_state     <= ST_ACC;
                    r_dp_op     <= DP_ACC;
                end
                ST_ACC: begin
                    if (w_done) begin
                        if (r_char_addr == r_len - 8'd1) begin
                            r_state <= ST_SUM;
                            r_dp_op <= DP_SUM;
                        end else begin
                            r_state      <= ST_FETCH;
                            r_dp_op      <= DP_NOP;
                            r_char_rd_en <= 1'b1;
                            r_char_addr  <= r_char_addr + 8'd1;
                        end
                    end
                end
                ST_SUM: begin
                    if (w_done) begin
                        r_state <= ST_THRESH;
                        r_dp_op <= DP_THRESH;
                    end
                end
                ST_THRESH: begin
                    if (w_done) begin
                        r_state <= ST_SIM;
                        r_dp_op <= DP_SIM;
                    end
                end
                ST_SIM: begin
                    if (w_done) begin
                        r_state <= ST_COMPARE;
                        r_dp_op <= DP_NOP;
                    end
                end
                ST_COMPARE: begin
                    if (i_score_ham > i_score_spam)
                        r_result <= RES_HAM;
                    else if (i_score_ham < i_score_spam)
                        r_result <= RES_SPAM;
                    else
                        r_result <= RES_NONE;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_dp_op <= DP_NOP;
                end
            endcase
        end
    end

    assign o_start_ready = (r_state == ST_IDLE);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_char_rd_en  = r_char_rd_en;
    assign o_char_addr   = r_char_addr;
    assign o_dp_op       = r_dp_op;
    assign o_dp_chunk    = w_chunk;
    assign o_dp_symbol   = r_dp_symbol;
    assign o_dp_last     = w_last;
    assign o_res_valid   = r_res_valid;
    assign o_result      = r_result;

endmodule
